// File: rtl/systolic_pkg.sv
// Shared constants, element types and the multiply-accumulate step used by
// every cell of the systolic MAC array.
// Optional build macro: SYSTOLIC_MAC_SAT_EN -- when defined, accumulation
// saturates to the signed accumulator range instead of wrapping.
package systolic_pkg;

    localparam int DIM_DEFAULT     = 8;
    localparam int BITS_AB_DEFAULT = 8;
    localparam int BITS_C_DEFAULT  = 16;

    typedef logic signed [BITS_AB_DEFAULT-1:0] operand_t;
    typedef logic signed [BITS_C_DEFAULT-1:0]  acc_t;

    // Working width for mac_step; wide enough for any accumulator width up to
    // 64 bits so one function serves every parameterisation of the cell.
    localparam int MAC_W = 64;
    typedef logic signed [MAC_W-1:0] wide_t;

    // One accumulation step: acc + a*b, with the product and the sum brought
    // into the bits_c-wide signed range. Inputs are sign-extended values.
    function automatic wide_t mac_step(input wide_t acc, input wide_t a,
                                       input wide_t b, input int bits_c);
        wide_t prod;
        wide_t sum;
        wide_t res;
        int    sh;
`ifdef SYSTOLIC_MAC_SAT_EN
        wide_t max_v;
        wide_t min_v;
`endif
        sh   = MAC_W - bits_c;
        prod = a * b;
        prod = (prod <<< sh) >>> sh;
        sum  = acc + prod;
        res  = (sum <<< sh) >>> sh;
`ifdef SYSTOLIC_MAC_SAT_EN
        max_v = (wide_t'(1) <<< (bits_c - 1)) - wide_t'(1);
        min_v = -max_v - wide_t'(1);
        // Like-signed operands giving an opposite-signed result means overflow.
        if ((acc[MAC_W-1] == prod[MAC_W-1]) && (res[MAC_W-1] != acc[MAC_W-1]))
            res = acc[MAC_W-1] ? min_v : max_v;
`endif
        return res;
    endfunction

endpackage

// File: rtl/systolic_mac_cell.sv
// Single processing element of the systolic MAC array: registers the A and B
// operands passing through and accumulates their product. A row write loads
// the accumulator directly and wins over accumulation; clear wins over all.
// Optional build macro: SYSTOLIC_MAC_SAT_EN (handled inside mac_step).
module systolic_mac_cell
    import systolic_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEFAULT,
    parameter int BITS_C  = BITS_C_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic               wr_i,
    input  logic [BITS_C-1:0]  wr_data_i,
    input  logic [BITS_AB-1:0] a_i,
    input  logic [BITS_AB-1:0] b_i,
    output logic [BITS_AB-1:0] a_o,
    output logic [BITS_AB-1:0] b_o,
    output logic [BITS_C-1:0]  acc_o
);

    logic signed [BITS_AB-1:0] a_q, a_d;
    logic signed [BITS_AB-1:0] b_q, b_d;
    logic signed [BITS_C-1:0]  acc_q, acc_d;
    wide_t                     mac_w;
    logic                      mac_hi_unused;

    // Candidate accumulator value for this cycle's operands.
    always_comb mac_w = mac_step(wide_t'(acc_q), wide_t'($signed(a_i)),
                                 wide_t'($signed(b_i)), BITS_C);

    assign mac_hi_unused = ^mac_w[MAC_W-1:BITS_C];

    // Next-state selection: clear, then shift/accumulate, then row write.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr_i) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else begin
            if (en_i) begin
                a_d   = a_i;
                b_d   = b_i;
                acc_d = mac_w[BITS_C-1:0];
            end
            if (wr_i)
                acc_d = wr_data_i;
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// DIM x DIM systolic multiply-accumulate array. A operands enter on the left
// and move right, B operands enter on the top and move down, one step per en
// cycle. Results are read one row at a time through Cout; a step counter
// raises done once the last skewed product has landed in the far corner.
// Optional build macro: SYSTOLIC_MAC_SAT_EN -- saturating accumulation.
module systolic_mac_array
    import systolic_pkg::*;
#(
    parameter int DIM     = DIM_DEFAULT,
    parameter int BITS_AB = BITS_AB_DEFAULT,
    parameter int BITS_C  = BITS_C_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [DIM*BITS_AB-1:0]  A,
    input  logic [DIM*BITS_AB-1:0]  B,
    input  logic                    WrEn,
    input  logic [$clog2(DIM)-1:0]  Crow,
    input  logic [DIM*BITS_C-1:0]   Cin,
    output logic [DIM*BITS_C-1:0]   Cout,
    output logic                    done
);

    localparam int ROW_W    = $clog2(DIM);
    localparam int CNT_W    = $clog2(3 * DIM);
    localparam int DONE_CNT = 3 * DIM - 2;

    logic [BITS_AB-1:0] a_link [DIM][DIM];
    logic [BITS_AB-1:0] b_link [DIM][DIM];
    logic [BITS_C-1:0]  acc_w  [DIM][DIM];
    logic [DIM-1:0]     row_wr;
    logic               row_valid;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    // Row select is always in range when DIM fills the Crow field exactly.
    if (DIM == (1 << ROW_W)) begin : g_row_full
        assign row_valid = 1'b1;
    end else begin : g_row_part
        assign row_valid = (Crow < ROW_W'(DIM));
    end

    // Per-row write strobe; out-of-range rows are never written.
    always_comb begin
        row_wr = '0;
        for (int r = 0; r < DIM; r++)
            row_wr[r] = WrEn && row_valid && (Crow == ROW_W'(r));
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            logic [BITS_AB-1:0] a_in;
            logic [BITS_AB-1:0] b_in;

            if (c == 0) begin : g_a_edge
                assign a_in = A[r*BITS_AB +: BITS_AB];
            end else begin : g_a_link
                assign a_in = a_link[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_in = B[c*BITS_AB +: BITS_AB];
            end else begin : g_b_link
                assign b_in = b_link[r-1][c];
            end

            systolic_mac_cell #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C)
            ) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .en_i      (en),
                .clr_i     (clr),
                .wr_i      (row_wr[r]),
                .wr_data_i (Cin[c*BITS_C +: BITS_C]),
                .a_i       (a_in),
                .b_i       (b_in),
                .a_o       (a_link[r][c]),
                .b_o       (b_link[r][c]),
                .acc_o     (acc_w[r][c])
            );
        end
    end

    // Row readout mux; an invalid row reads as zero.
    always_comb begin
        Cout = '0;
        if (row_valid) begin
            for (int c = 0; c < DIM; c++)
                Cout[c*BITS_C +: BITS_C] = acc_w[Crow][c];
        end
    end

    // Step counter saturating at the last-product step; done tracks it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != CNT_W'(DONE_CNT)))
            cnt_d = cnt_q + CNT_W'(1);
        done_d = (cnt_d == CNT_W'(DONE_CNT));
    end

    // Counter and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Self-checking bench for systolic_mac_array: skewed matrix products against a
// plain matrix-multiply model, stalls, row writes, clear priority, signed
// overflow behaviour and asynchronous reset.
module tb_systolic_mac_array;

    localparam int DIM   = 8;
    localparam int BA    = 8;
    localparam int BC    = 16;
    localparam int NSTEP = 3 * DIM - 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [DIM*BA-1:0] A;
    logic [DIM*BA-1:0] B;
    logic              WrEn;
    logic [2:0]        Crow;
    logic [DIM*BC-1:0] Cin;
    logic [DIM*BC-1:0] Cout;
    logic              done;

    int errors = 0;
    int checks = 0;

    int ma [DIM][DIM];
    int mb [DIM][DIM];
    int mc [DIM][DIM];

    systolic_mac_array #(.DIM(DIM), .BITS_AB(BA), .BITS_C(BC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .A    (A),
        .B    (B),
        .WrEn (WrEn),
        .Crow (Crow),
        .Cin  (Cin),
        .Cout (Cout),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fold16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int acc_add(input int acc, input int p);
        int s;
        s = acc + fold16(p);
`ifdef SYSTOLIC_MAC_SAT_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        return fold16(s);
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mc[r][c] = 0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    task automatic check_rows(input string tag);
        for (int r = 0; r < DIM; r++) begin
            Crow = 3'(r);
            #1;
            for (int c = 0; c < DIM; c++)
                chk(tag, $signed(Cout[c*BC +: BC]), mc[r][c]);
        end
    endtask

    task automatic fill_identity();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = r * DIM + c;
            end
    endtask

    task automatic fill_random();
        logic signed [7:0] v;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                v = 8'($urandom);
                ma[r][c] = int'(v);
                v = 8'($urandom);
                mb[r][c] = int'(v);
            end
    endtask

    task automatic compute_product();
        int acc;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++)
                    acc = acc_add(acc, ma[r][k] * mb[k][c]);
                mc[r][c] = acc;
            end
    endtask

    task automatic drive_step(input int t);
        int k;
        for (int i = 0; i < DIM; i++) begin
            k = t - i;
            A[i*BA +: BA] = (k >= 0 && k < DIM) ? 8'(ma[i][k]) : 8'd0;
            B[i*BA +: BA] = (k >= 0 && k < DIM) ? 8'(mb[k][i]) : 8'd0;
        end
    endtask

    task automatic run_matrix(input string tag, input int stall_at, input int stall_len);
        int en_cnt;
        en_cnt = 0;
        for (int t = 0; t < NSTEP; t++) begin
            if (t == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    en = 1'b0;
                    A  = {$urandom(), $urandom()};
                    B  = {$urandom(), $urandom()};
                    tick();
                    chk({tag, "_stall_done"}, done, 0);
                end
            end
            en = 1'b1;
            drive_step(t);
            tick();
            en_cnt++;
            chk({tag, "_done"}, done, (en_cnt == NSTEP) ? 1 : 0);
        end
        en = 1'b0;
        A  = '0;
        B  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        A     = '0;
        B     = '0;
        WrEn  = 1'b0;
        Crow  = '0;
        Cin   = '0;
        model_clear();
        #12;
        chk("reset_done", done, 0);
        check_rows("reset_cout");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Identity A: every row of C must equal the matching row of B.
        do_clr();
        fill_identity();
        compute_product();
        run_matrix("ident", -1, 0);
        check_rows("ident_c");

        // Random signed matrices, no stall.
        do_clr();
        fill_random();
        compute_product();
        run_matrix("rand", -1, 0);
        check_rows("rand_c");

        // Random signed matrices with a 5-cycle stall mid-stream.
        do_clr();
        fill_random();
        compute_product();
        run_matrix("stall", 10, 5);
        check_rows("stall_c");

        // Row write with en low: only row 3 changes, done holds.
        for (int c = 0; c < DIM; c++) begin
            Cin[c*BC +: BC] = 16'h1234;
            mc[3][c] = 16'h1234;
        end
        Crow = 3'd3;
        WrEn = 1'b1;
        tick();
        WrEn = 1'b0;
        check_rows("wr_c");
        chk("wr_done_hold", done, 1);

        // Clear beats en and WrEn together.
        clr  = 1'b1;
        en   = 1'b1;
        WrEn = 1'b1;
        Crow = 3'd2;
        A    = {$urandom(), $urandom()};
        B    = {$urandom(), $urandom()};
        tick();
        clr  = 1'b0;
        en   = 1'b0;
        WrEn = 1'b0;
        model_clear();
        chk("clr_done", done, 0);
        check_rows("clr_c");

        // Counter restarted from zero: done needs exactly NSTEP more en cycles.
        A  = '0;
        B  = '0;
        en = 1'b1;
        for (int i = 0; i < NSTEP - 1; i++) tick();
        chk("cnt_pre_done", done, 0);
        tick();
        chk("cnt_done", done, 1);
        en = 1'b0;

        // Row write wins over accumulation for its row only.
        do_clr();
        en = 1'b1;
        B[0 +: BA] = 8'd3;
        tick();
        A[0 +: BA]  = 8'd2;
        A[BA +: BA] = 8'd5;
        Cin  = '0;
        Cin[0 +: BC] = 16'd100;
        Crow = 3'd0;
        WrEn = 1'b1;
        tick();
        WrEn = 1'b0;
        en   = 1'b0;
        A    = '0;
        B    = '0;
        mc[0][0] = 100;
        mc[1][0] = 15;
        check_rows("wr_prio_c");

        // 127*127 accumulated three times in cell (0,0).
        do_clr();
        A[0 +: BA] = 8'sd127;
        B[0 +: BA] = 8'sd127;
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        A  = '0;
        B  = '0;
        Crow = 3'd0;
        #1;
`ifdef SYSTOLIC_MAC_SAT_EN
        chk("ovf_pos", $signed(Cout[0 +: BC]), 32767);
`else
        chk("ovf_pos", $signed(Cout[0 +: BC]), -17149);
`endif

        // Most negative operand times 127, once.
        do_clr();
        A[0 +: BA] = 8'h80;
        B[0 +: BA] = 8'sd127;
        en = 1'b1;
        tick();
        en = 1'b0;
        A  = '0;
        B  = '0;
        Crow = 3'd0;
        #1;
        chk("neg_prod", $signed(Cout[0 +: BC]), -16256);

        // Asynchronous reset in the middle of a run, no clock edge needed.
        do_clr();
        fill_random();
        compute_product();
        run_matrix("pre_rst", -1, 0);
        en = 1'b1;
        fill_random();
        drive_step(0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_done", done, 0);
        model_clear();
        check_rows("arst_c");
        en = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
